// File: rtl/ureg_pkg.sv
// Shared types and default sizes for the 4-bit universal shift register,
// its command sequencer and their benches.
package ureg_pkg;

    localparam int unsigned UREG_WIDTH = 4;
    localparam int unsigned UREG_CNT_W = 4;

    typedef enum logic [1:0] {
        MODE_SISO = 2'b00,
        MODE_SIPO = 2'b01,
        MODE_PISO = 2'b10,
        MODE_PIPO = 2'b11
    } mode_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_RESP   = 3'd4
    } seq_state_t;

endpackage

// File: rtl/ureg_cmd_sequencer.sv
// Command stage for the universal shift register: takes one command per
// handshake, drives the register pins, and returns the collected result.
module ureg_cmd_sequencer
    import ureg_pkg::*;
#(
    parameter int unsigned WIDTH = UREG_WIDTH,
    parameter int unsigned CNT_W = UREG_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_shifts,
    input  logic             stall,
    output logic             reg_enable,
    output logic [1:0]       reg_mode,
    output logic             reg_load,
    output logic             reg_serial_in,
    output logic [WIDTH-1:0] reg_parallel_in,
    input  logic             reg_serial_out,
    input  logic [WIDTH-1:0] reg_parallel_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);

    localparam int unsigned IW = $clog2(WIDTH);

    seq_state_t       state;
    mode_t            mode_q;
    logic [WIDTH-1:0] data_q;
    logic [CNT_W-1:0] shifts_q;
    logic [CNT_W-1:0] k_q;
    logic [IW-1:0]    pos_q;
    logic [WIDTH-1:0] capture_q;
    logic [WIDTH-1:0] rsp_q;
    logic [IW-1:0]    bit_idx;

    // pos_q tracks k mod WIDTH so long shift counts rotate through the data
    assign bit_idx = IW'(WIDTH - 1) - pos_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            mode_q    <= MODE_SISO;
            data_q    <= '0;
            shifts_q  <= '0;
            k_q       <= '0;
            pos_q     <= '0;
            capture_q <= '0;
            rsp_q     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        mode_q    <= mode_t'(cmd_mode);
                        data_q    <= cmd_data;
                        shifts_q  <= cmd_shifts;
                        k_q       <= '0;
                        pos_q     <= '0;
                        capture_q <= '0;
                        if (cmd_mode[1])
                            state <= ST_LOAD;
                        else if (cmd_shifts == '0)
                            state <= ST_SETTLE;
                        else
                            state <= ST_SHIFT;
                    end
                end
                ST_LOAD: begin
                    if (!stall) begin
                        if (mode_q == MODE_PIPO || shifts_q == '0)
                            state <= ST_SETTLE;
                        else
                            state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (!stall) begin
                        k_q       <= k_q + CNT_W'(1);
                        pos_q     <= (pos_q == IW'(WIDTH - 1)) ? '0 : pos_q + IW'(1);
                        capture_q <= {capture_q[WIDTH-2:0], reg_serial_out};
                        if (k_q == shifts_q - CNT_W'(1))
                            state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (mode_q == MODE_SIPO || mode_q == MODE_PIPO)
                        rsp_q <= reg_parallel_out;
                    else
                        rsp_q <= capture_q;
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Moore decode; only reg_enable sees stall so a frozen cycle never clocks the register
    assign cmd_ready       = (state == ST_IDLE);
    assign busy            = (state != ST_IDLE);
    assign rsp_valid       = (state == ST_RESP);
    assign rsp_data        = rsp_q;
    assign reg_enable      = (state == ST_LOAD || state == ST_SHIFT) && !stall;
    assign reg_load        = (state == ST_LOAD);
    assign reg_mode        = mode_q;
    assign reg_parallel_in = data_q;
    assign reg_serial_in   = (state == ST_SHIFT) && !mode_q[1] && data_q[bit_idx];

endmodule

// File: tb/tb_ureg_cmd_sequencer.sv
// Bench for ureg_cmd_sequencer driving a behavioural universal shift register.
module tb_ureg_cmd_sequencer;
    import ureg_pkg::*;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_mode;
    logic [3:0] cmd_data;
    logic [3:0] cmd_shifts;
    logic       stall;
    logic       reg_enable;
    logic [1:0] reg_mode;
    logic       reg_load;
    logic       reg_serial_in;
    logic [3:0] reg_parallel_in;
    logic       reg_serial_out;
    logic [3:0] reg_parallel_out;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic       busy;

    ureg_cmd_sequencer #(.WIDTH(4), .CNT_W(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_mode         (cmd_mode),
        .cmd_data         (cmd_data),
        .cmd_shifts       (cmd_shifts),
        .stall            (stall),
        .reg_enable       (reg_enable),
        .reg_mode         (reg_mode),
        .reg_load         (reg_load),
        .reg_serial_in    (reg_serial_in),
        .reg_parallel_in  (reg_parallel_in),
        .reg_serial_out   (reg_serial_out),
        .reg_parallel_out (reg_parallel_out),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_data         (rsp_data),
        .busy             (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural universal register: load wins, otherwise shift toward MSB
    logic [3:0] ureg_q;
    always_ff @(posedge clk) begin
        if (rst)
            ureg_q <= '0;
        else if (reg_enable) begin
            if (reg_load)
                ureg_q <= reg_parallel_in;
            else if (reg_mode != MODE_PIPO)
                ureg_q <= {ureg_q[2:0], reg_serial_in};
        end
    end
    assign reg_serial_out   = ureg_q[3];
    assign reg_parallel_out = ureg_q;

    int         shift_cnt;
    int         load_cnt;
    logic [15:0] sin_log;

    always @(posedge clk) begin
        if (!rst && reg_enable) begin
            if (reg_load)
                load_cnt = load_cnt + 1;
            else begin
                shift_cnt = shift_cnt + 1;
                sin_log   = {sin_log[14:0], reg_serial_in};
            end
        end
    end

    int tests;
    int failed;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        mode_t       mode;
        logic [3:0]  data;
        logic [3:0]  shifts;
        int          stall_after;
        int          stall_len;
        int          hold;
        logic [3:0]  exp_rsp;
        int          exp_lat;
        int          exp_shifts;
        int          exp_loads;
        logic [15:0] exp_sin;
    } vec_t;

    task automatic run_cmd(input vec_t v, input int idx);
        int   lat;
        int   stall_done;
        logic got;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        chk({tag, " cmd_ready idle"}, cmd_ready, 1);
        cmd_valid  = 1'b1;
        cmd_mode   = v.mode;
        cmd_data   = v.data;
        cmd_shifts = v.shifts;
        rsp_ready  = 1'b0;
        shift_cnt  = 0;
        load_cnt   = 0;
        sin_log    = '0;
        stall_done = 0;
        @(posedge clk);
        #1;
        cmd_valid  = 1'b0;
        cmd_data   = ~v.data;
        cmd_shifts = ~v.shifts;
        lat = 0;
        got = 1'b0;
        for (int c = 0; c < 64 && !got; c++) begin
            @(negedge clk);
            if (v.stall_len > 0 && shift_cnt == v.stall_after && stall_done < v.stall_len) begin
                stall = 1'b1;
                stall_done++;
            end else
                stall = 1'b0;
            #1;
            if (stall)
                chk({tag, " enable low in stall"}, reg_enable, 0);
            if (rsp_valid)
                got = 1'b1;
            else begin
                @(posedge clk);
                lat++;
            end
        end
        stall = 1'b0;
        chk({tag, " rsp_valid seen"}, got, 1);
        chk({tag, " latency"}, lat, v.exp_lat);
        chk({tag, " rsp_data"}, rsp_data, v.exp_rsp);
        chk({tag, " shift edges"}, shift_cnt, v.exp_shifts);
        chk({tag, " load edges"}, load_cnt, v.exp_loads);
        chk({tag, " serial_in seq"}, sin_log, v.exp_sin);
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            chk({tag, " hold rsp_valid"}, rsp_valid, 1);
            chk({tag, " hold rsp_data"}, rsp_data, v.exp_rsp);
            chk({tag, " hold cmd_ready"}, cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        #1;
        chk({tag, " cmd_ready in handshake"}, cmd_ready, 0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk({tag, " rsp_valid dropped"}, rsp_valid, 0);
        chk({tag, " idle after rsp"}, {busy, cmd_ready}, 2'b01);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " cmd_ready"}, cmd_ready, 1);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " rsp_valid"}, rsp_valid, 0);
        chk({tag, " rsp_data"}, rsp_data, 0);
        chk({tag, " reg_enable"}, reg_enable, 0);
        chk({tag, " reg_load"}, reg_load, 0);
        chk({tag, " reg_mode"}, reg_mode, 0);
        chk({tag, " reg_serial_in"}, reg_serial_in, 0);
        chk({tag, " reg_parallel_in"}, reg_parallel_in, 0);
    endtask

    vec_t vecs[12];

    initial begin
        logic saw_rsp;
        tests      = 0;
        failed     = 0;
        shift_cnt  = 0;
        load_cnt   = 0;
        sin_log    = '0;
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_mode   = 2'b00;
        cmd_data   = 4'h0;
        cmd_shifts = 4'h0;
        stall      = 1'b0;
        rsp_ready  = 1'b0;

        // mode data shifts stall_after stall_len hold rsp lat nsh nld sin
        vecs[0]  = '{MODE_PIPO, 4'b1110, 4'd5,  0, 0, 0, 4'b1110,  2,  0, 1, 16'h0000};
        vecs[1]  = '{MODE_SIPO, 4'b1100, 4'd4,  0, 0, 0, 4'b1100,  5,  4, 0, 16'h000C};
        vecs[2]  = '{MODE_PISO, 4'b0110, 4'd4,  0, 0, 1, 4'b0110,  6,  4, 1, 16'h0000};
        vecs[3]  = '{MODE_SISO, 4'b1011, 4'd8,  0, 0, 0, 4'b1011,  9,  8, 0, 16'h00BB};
        vecs[4]  = '{MODE_SISO, 4'b0101, 4'd2,  0, 0, 0, 4'b0010,  3,  2, 0, 16'h0001};
        vecs[5]  = '{MODE_SIPO, 4'b1001, 4'd6,  0, 0, 0, 4'b0110,  7,  6, 0, 16'h0026};
        vecs[6]  = '{MODE_PISO, 4'b1010, 4'd2,  0, 0, 0, 4'b0010,  4,  2, 1, 16'h0000};
        vecs[7]  = '{MODE_PISO, 4'b0111, 4'd0,  0, 0, 0, 4'b0000,  2,  0, 1, 16'h0000};
        vecs[8]  = '{MODE_SIPO, 4'b1111, 4'd0,  0, 0, 3, 4'b0111,  1,  0, 0, 16'h0000};
        vecs[9]  = '{MODE_PIPO, 4'b0000, 4'd3,  0, 0, 0, 4'b0000,  2,  0, 1, 16'h0000};
        vecs[10] = '{MODE_SIPO, 4'b1000, 4'd15, 0, 0, 0, 4'b0100, 16, 15, 0, 16'h4444};
        vecs[11] = '{MODE_PISO, 4'b0110, 4'd4,  2, 2, 0, 4'b0110,  8,  4, 1, 16'h0000};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("reset");

        for (int i = 0; i < 12; i++)
            run_cmd(vecs[i], i);

        // Reset in the third shift cycle of a SIPO command aborts it
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_mode   = MODE_SIPO;
        cmd_data   = 4'b1010;
        cmd_shifts = 4'd4;
        shift_cnt  = 0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        for (int c = 0; c < 20 && shift_cnt < 2; c++)
            @(negedge clk);
        chk("abort reached shift 3", {busy, reg_enable, reg_mode}, {2'b11, 2'b01});
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("abort");
        chk("abort no extra shift", shift_cnt, 2);
        rst = 1'b0;
        saw_rsp = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid || busy)
                saw_rsp = 1'b1;
        end
        chk("abort stays idle", saw_rsp, 0);

        run_cmd('{MODE_SIPO, 4'b0011, 4'd4, 0, 0, 0, 4'b0011, 5, 4, 0, 16'h0003}, 12);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
